// File: rtl/mul_sched.sv
// Round-robin scheduler for two requesters sharing one 25x25 multiplier.
// Sequences the multiplier's en/in_sel pins for square and chained jobs and returns tagged results.
module mul_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [24:0]      req0_x,
  input  logic [24:0]      req0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [24:0]      req1_x,
  input  logic [24:0]      req1_c,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [48:0]      resp_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             mul_en,
  output logic             mul_in_sel,
  output logic [24:0]      mul_in1,
  output logic [24:0]      mul_in2,
  input  logic [48:0]      mul_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQ_CAP  = 3'd1,
    SQ_WAIT = 3'd2,
    CH_CAP  = 3'd3,
    CH_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [24:0]       x_reg, c_reg;
  logic              op_reg, id_reg, last_grant_reg;
  logic [CNT_W-1:0]  count_reg;

  logic [1:0]        req_valid, req_op, req_ready;
  logic [24:0]       req_x [2];
  logic [24:0]       req_c [2];
  logic              grant, accept;

  assign req_valid = {req1_valid, req0_valid};
  assign req_op    = {req1_op, req0_op};
  assign req_x[0]  = req0_x;
  assign req_x[1]  = req1_x;
  assign req_c[0]  = req0_c;
  assign req_c[1]  = req1_c;

  // On contention favour the requester that was not served last.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11)
      grant = ~last_grant_reg;
    else if (req_valid[1])
      grant = 1'b1;
  end

  assign accept = (state_reg == IDLE) && (req_valid != 2'b00);

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant == 1'(gi));
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  always_comb begin
    state_next = state_reg;
    mul_en     = 1'b0;
    mul_in_sel = 1'b0;
    resp_valid = 1'b0;
    unique case (state_reg)
      IDLE:    if (accept) state_next = SQ_CAP;
      SQ_CAP: begin
        mul_en     = 1'b1;
        state_next = SQ_WAIT;
      end
      SQ_WAIT: state_next = op_reg ? CH_CAP : RESP;
      CH_CAP: begin
        mul_en     = 1'b1;
        mul_in_sel = 1'b1;
        state_next = CH_WAIT;
      end
      CH_WAIT: begin
        mul_in_sel = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The multiplier holds mulout while en stays low, so RESP can pass it straight through.
  assign resp_data = resp_valid ? mul_out : '0;
  assign resp_id   = id_reg;
  assign busy      = (state_reg != IDLE);
  assign op_count  = count_reg;
  assign mul_in1   = x_reg;
  assign mul_in2   = c_reg;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      x_reg          <= '0;
      c_reg          <= '0;
      op_reg         <= 1'b0;
      id_reg         <= 1'b0;
      last_grant_reg <= 1'b1;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        x_reg          <= req_x[grant];
        c_reg          <= req_c[grant];
        op_reg         <= req_op[grant];
        id_reg         <= grant;
        last_grant_reg <= grant;
      end
      if (state_reg == RESP && resp_ready)
        count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched with a behavioural model of the shared multiplier.
module tb_mul_sched;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_op = 1'b0, req1_op = 1'b0;
  logic [24:0]   req0_x = '0, req0_c = '0, req1_x = '0, req1_c = '0;
  logic          req0_ready, req1_ready;
  logic          resp_valid, resp_id, busy, mul_en, mul_in_sel;
  logic          resp_ready = 1'b0;
  logic [48:0]   resp_data, mul_out;
  logic [CW-1:0] op_count;
  logic [24:0]   mul_in1, mul_in2;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  mul_sched #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_x(req0_x), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_x(req1_x), .req1_c(req1_c),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .op_count(op_count),
    .mul_en(mul_en), .mul_in_sel(mul_in_sel), .mul_in1(mul_in1), .mul_in2(mul_in2),
    .mul_out(mul_out)
  );

  // Multiplier model: captures when idle and en, result appears one negedge later.
  function automatic logic [48:0] smul(input logic signed [24:0] a, input logic signed [24:0] b);
    logic signed [49:0] p;
    p = a * b;
    return p[48:0];
  endfunction

  logic        mm_busy;
  logic [48:0] mm_pend;
  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      mul_out <= '0;
      mm_busy <= 1'b0;
      mm_pend <= '0;
    end else if (mm_busy) begin
      mul_out <= mm_pend;
      mm_busy <= 1'b0;
    end else if (mul_en) begin
      mm_pend <= mul_in_sel ? smul(mul_out[29:5], mul_in2) : smul(mul_in1, mul_in1);
      mm_busy <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_job(input logic rq, input logic op, input logic [24:0] x, input logic [24:0] c,
                         output int lat, output int ens, output int selp,
                         output logic [48:0] d, output logic id);
    int w;
    @(posedge clk);
    if (rq) begin
      req1_valid = 1'b1; req1_op = op; req1_x = x; req1_c = c;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_x = x; req0_c = c;
    end
    w = 0;
    #1;
    while (!(rq ? req1_ready : req0_ready) && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("accept_wait", 64'(w < 20), 64'(1));
    @(posedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    lat = 1; ens = 0; selp = 0;
    while (!resp_valid && lat < 20) begin
      if (mul_en) begin
        ens++;
        selp = selp * 2 + int'(mul_in_sel);
      end
      @(posedge clk); #1; lat++;
    end
    d  = resp_data;
    id = resp_id;
  endtask

  typedef struct {
    logic        rq;
    logic        op;
    logic [24:0] x;
    logic [24:0] c;
    logic [48:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    int lat, ens, selp, ngr, nresp, last_cyc, both_rdy, busy_rdy, guard;
    logic [48:0] d, d0;
    logic id;
    logic grants [4];

    vecs[0] = '{1'b0, 1'b0, 25'sd100,       25'sd0,  49'sd10000};
    vecs[1] = '{1'b1, 1'b1, 25'sd4096,      25'sd3,  49'sd1572864};
    vecs[2] = '{1'b0, 1'b0, -25'sd1,        25'sd0,  49'sd1};
    vecs[3] = '{1'b1, 1'b1, 25'sd4096,      -25'sd2, -49'sd1048576};
    vecs[4] = '{1'b0, 1'b1, 25'sd1000,      25'sd5,  49'sd156250};
    vecs[5] = '{1'b1, 1'b1, -25'sd100,      -25'sd7, -49'sd2184};
    vecs[6] = '{1'b0, 1'b0, 25'sd16777215,  25'sd0,  49'sd281474943156225};
    vecs[7] = '{1'b1, 1'b0, -25'sd16777216, 25'sd0,  49'h1000000000000};
    vecs[8] = '{1'b0, 1'b1, 25'sd23171,     25'sd1,  -49'sd16776456};
    vecs[9] = '{1'b1, 1'b0, -25'sd4096,     25'sd0,  49'sd16777216};

    // Reset values
    #12;
    chk("rst_busy",       64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_data",  64'(resp_data), 64'(0));
    chk("rst_resp_id",    64'(resp_id), 64'(0));
    chk("rst_op_count",   64'(op_count), 64'(0));
    chk("rst_mul_en",     64'(mul_en), 64'(0));
    chk("rst_in_sel",     64'(mul_in_sel), 64'(0));
    chk("rst_mul_in1",    64'(mul_in1), 64'(0));
    chk("rst_mul_in2",    64'(mul_in2), 64'(0));
    @(posedge clk); @(posedge clk);
    reset = 1'b1;

    // Contention: both valid, grants must alternate starting at req0, 4 edges apart
    @(posedge clk);
    req0_valid = 1'b1; req0_op = 1'b0; req0_x = 25'd3;
    req1_valid = 1'b1; req1_op = 1'b0; req1_x = 25'd5;
    resp_ready = 1'b1;
    ngr = 0; nresp = 0; last_cyc = 0; both_rdy = 0; busy_rdy = 0;
    for (int cyc = 0; cyc < 80 && nresp < 4; cyc++) begin
      if (ngr == 4) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      #1;
      if (req0_ready && req1_ready) both_rdy++;
      if (busy && (req0_ready || req1_ready)) busy_rdy++;
      if (resp_valid) begin
        chk("rr_resp_id", 64'(resp_id), 64'(grants[nresp]));
        chk("rr_resp_data", 64'(resp_data), grants[nresp] ? 64'(25) : 64'(9));
        nresp++;
        exp_cnt = (exp_cnt + 1) % 16;
      end
      if ((req0_ready || req1_ready) && ngr < 4) begin
        grants[ngr] = req1_ready;
        chk("rr_grant", 64'(req1_ready), 64'(ngr % 2));
        if (ngr > 0) chk("rr_interval", 64'(cyc - last_cyc), 64'(4));
        last_cyc = cyc;
        ngr++;
      end
      @(posedge clk);
    end
    chk("rr_responses", 64'(nresp), 64'(4));
    chk("rr_both_ready", 64'(both_rdy), 64'(0));
    chk("rr_ready_busy", 64'(busy_rdy), 64'(0));
    #1;
    chk("rr_op_count", 64'(op_count), 64'(exp_cnt));

    // Table-driven jobs with resp_ready tied high
    for (int i = 0; i < 10; i++) begin
      run_job(vecs[i].rq, vecs[i].op, vecs[i].x, vecs[i].c, lat, ens, selp, d, id);
      $display("vec %0d rq=%0d op=%0d x=%0h c=%0h -> data=%0h id=%0d lat=%0d",
               i, vecs[i].rq, vecs[i].op, vecs[i].x, vecs[i].c, d, id, lat);
      chk("vec_data",    64'(d), 64'(vecs[i].exp));
      chk("vec_id",      64'(id), 64'(vecs[i].rq));
      chk("vec_latency", 64'(lat), vecs[i].op ? 64'(5) : 64'(3));
      chk("vec_en_cnt",  64'(ens), vecs[i].op ? 64'(2) : 64'(1));
      chk("vec_sel_seq", 64'(selp), vecs[i].op ? 64'(1) : 64'(0));
      @(posedge clk); #1;
      exp_cnt = (exp_cnt + 1) % 16;
      chk("vec_idle",  64'(busy), 64'(0));
      chk("vec_count", 64'(op_count), 64'(exp_cnt));
    end

    // Run squares until the counter wraps to zero
    guard = 0;
    while (exp_cnt != 0 && guard < 20) begin
      run_job(1'b0, 1'b0, 25'(guard + 11), 25'd0, lat, ens, selp, d, id);
      chk("wrap_data", 64'(d), 64'((guard + 11) * (guard + 11)));
      @(posedge clk); #1;
      exp_cnt = (exp_cnt + 1) % 16;
      $display("wrap job %0d -> op_count=%0d", guard, op_count);
      chk("wrap_count", 64'(op_count), 64'(exp_cnt));
      guard++;
    end

    // Hold resp_ready low in RESP with another request pending
    resp_ready = 1'b0;
    run_job(1'b0, 1'b0, 25'd12, 25'd0, lat, ens, selp, d0, id);
    chk("hold_first", 64'(d0), 64'(144));
    req1_valid = 1'b1; req1_op = 1'b0; req1_x = 25'd6; req1_c = 25'd0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("hold_data",  64'(resp_data), 64'(d0));
      chk("hold_valid", 64'(resp_valid), 64'(1));
      chk("hold_en",    64'(mul_en), 64'(0));
      chk("hold_ready", 64'(req1_ready), 64'(0));
    end
    chk("hold_count", 64'(op_count), 64'(exp_cnt));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) % 16;
    chk("release_idle",  64'(busy), 64'(0));
    chk("release_ready", 64'(req1_ready), 64'(1));
    chk("release_count", 64'(op_count), 64'(exp_cnt));
    @(posedge clk);
    req1_valid = 1'b0;
    #1;
    guard = 0;
    while (!resp_valid && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    $display("pending job -> data=%0h id=%0d", resp_data, resp_id);
    chk("pending_data", 64'(resp_data), 64'(36));
    chk("pending_id",   64'(resp_id), 64'(1));
    @(posedge clk); #1;
    exp_cnt = (exp_cnt + 1) % 16;

    // Reset during CH_WAIT aborts the job
    @(posedge clk);
    req0_valid = 1'b1; req0_op = 1'b1; req0_x = 25'd4096; req0_c = 25'd3;
    #1;
    chk("abort_accept", 64'(req0_ready), 64'(1));
    @(posedge clk);
    req0_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("chwait_sel",  64'(mul_in_sel), 64'(1));
    chk("chwait_en",   64'(mul_en), 64'(0));
    chk("chwait_busy", 64'(busy), 64'(1));
    reset = 1'b0;
    #1;
    chk("abort_busy",       64'(busy), 64'(0));
    chk("abort_resp_valid", 64'(resp_valid), 64'(0));
    chk("abort_resp_data",  64'(resp_data), 64'(0));
    chk("abort_resp_id",    64'(resp_id), 64'(0));
    chk("abort_count",      64'(op_count), 64'(0));
    chk("abort_en",         64'(mul_en), 64'(0));
    chk("abort_sel",        64'(mul_in_sel), 64'(0));
    chk("abort_in1",        64'(mul_in1), 64'(0));
    chk("abort_in2",        64'(mul_in2), 64'(0));
    exp_cnt = 0;
    @(posedge clk);
    reset = 1'b1;
    run_job(1'b0, 1'b0, 25'd7, 25'd0, lat, ens, selp, d, id);
    $display("post-reset square x=7 -> data=%0h lat=%0d", d, lat);
    chk("post_data",    64'(d), 64'(49));
    chk("post_latency", 64'(lat), 64'(3));
    chk("post_en_cnt",  64'(ens), 64'(1));
    @(posedge clk); #1;
    chk("post_count", 64'(op_count), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Two-requester scheduler for the shared 25x25 Booth multiplier (`multiplier`). It accepts square (x*x) and chained (c * (x*x)[29:5]) jobs from two clients over valid/ready and arbitrates them round-robin. It sequences the multiplier's `en`/`in_sel` pins around its two-edge capture/result cycle and returns each 49-bit result with the requester id. It sits between the filter-coefficient datapath clients and the single multiplier instance; it is the multiplier's only driver.

## Interface
- CNT_W, 16, width of completed-job counter
- clk  in  1  clock; all flops on negedge, matching the multiplier
- reset  in  1  asynchronous, active-low; shared with the multiplier instance
- req0_valid / req1_valid  in  1  job request
- req0_ready / req1_ready  out  1  job accepted at this negedge when valid&ready
- req0_op / req1_op  in  1  0 = square, 1 = chain
- req0_x / req1_x  in  25  operand x, two's complement
- req0_c / req1_c  in  25  chain coefficient c, two's complement (ignored for op=0)
- resp_valid  out  1  result available
- resp_ready  in  1  result consumer ready
- resp_id  out  1  requester of current result
- resp_data  out  49  result, two's complement
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed jobs, wraps
- mul_en, mul_in_sel  out  1  to multiplier `en`, `in_sel`
- mul_in1, mul_in2  out  25  to multiplier `in1_1`, `in2_2`
- mul_out  in  49  from multiplier `mulout`

## Operation
- Multiplier contract: `en` sampled only in its internal idle state; product visible on `mulout` one negedge after capture. `in_sel=1` uses the current `mulout[29:5]` as one operand and `in2_2` as the other.
- States: IDLE, SQ_CAP, SQ_WAIT, CH_CAP, CH_WAIT, RESP.
- IDLE: if any reqN_valid, grant one; latch x, c, op, id; next SQ_CAP. reqN_ready is combinational: high only in IDLE for the granted requester.
- Round-robin: both valid -> grant the requester not granted last; one valid -> grant it. last_grant resets to 1, so req0 wins first contention.
- SQ_CAP: mul_en=1, mul_in_sel=0, mul_in1=x -> SQ_WAIT.
- SQ_WAIT: mul_en=0 -> CH_CAP if op=1, else RESP.
- CH_CAP: mul_en=1, mul_in_sel=1, mul_in2=c -> CH_WAIT.
- CH_WAIT: mul_en=0, mul_in_sel=1 -> RESP.
- RESP: resp_valid=1, resp_data=mul_out, resp_id=latched id. On resp_ready, op_count+1 and go to IDLE. Otherwise hold; mul_out stays stable because no en is issued.
- mul_en is decoded from state and is high for exactly one negedge per CAP state.
- mul_in1/mul_in2 are driven from latched x/c in every state; they are 0 after reset.
- Arithmetic: square = x*x. chain = c * sext25(sq[29:5]). Both are 49-bit two's complement. No saturation.

## Timing
- Reset values: state IDLE, all ready/valid/en/in_sel 0, resp_data 0, resp_id 0, op_count 0, last_grant 1.
- Reset asserted mid-job aborts it: no response, and the multiplier resets together with this block.
- Square latency: accept at negedge E0 -> capture E1 -> mulout E2 -> resp_valid high after E2.
- Chain latency: resp_valid high after E4.
- Back-to-back: a new request can be accepted at the negedge after the resp handshake at the earliest. Throughput is 1 square per 4 edges with resp_ready tied high.
- A request arriving while busy waits; its valid and data must be held. Requests in RESP are not accepted until the handshake completes.
- A requester dropping valid before ready is a protocol violation (not checked).
- op_count wraps 2^CNT_W-1 -> 0.

## Test plan
- Reset, then req0 square x=100 with resp_ready=1 -> mul_en pulse one edge, resp_valid after 3rd negedge, resp_data=10000, resp_id=0, op_count=1.
- req1 chain x=4096, c=3 -> sq=2^24 so sq[29:5]=524288; two mul_en pulses with in_sel 0 then 1; resp_data=1572864 after 5th negedge, resp_id=1.
- Negative operands: square x=-1 -> 1. Chain x=4096, c=-2 -> -1048576, sign-extended to 49 bits.
- Both valid continuously, 4 jobs -> grants alternate 0,1,0,1 starting with 0. Neither req ready while busy.
- Hold resp_ready=0 for 10 edges in RESP -> resp_data stable, no mul_en, no accept. Releasing it -> IDLE next edge.
- Assert reset during CH_WAIT -> all outputs 0 immediately; after release, a fresh square x=7 returns 49 with correct latency.
